// File: rtl/capture_ctrl_pkg.sv
// Shared types and defaults for the LA_dig capture sequencer.
package capture_ctrl_pkg;

    localparam int LA_AW = 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Control/status bundle between cmd_cfg, trigger logic, RAM write port and capture_ctrl.
// Handshake: inputs are plain levels or one-cycle strobes sampled on clk; no valid/ready pairs.
interface capture_ctrl_if #(parameter int AW = capture_ctrl_pkg::LA_AW);
    import capture_ctrl_pkg::*;

    logic          run;
    logic          wrt_smpl;
    logic          trig;
    logic [AW-1:0] trig_pos;
    logic          cap_done_clr;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          triggered;
    logic          capture_done;
    logic [AW-1:0] trig_addr;
    cap_state_t    state;

    modport slave (
        input  run, wrt_smpl, trig, trig_pos, cap_done_clr,
        output we, waddr, armed, triggered, capture_done, trig_addr, state
    );

    modport master (
        output run, wrt_smpl, trig, trig_pos, cap_done_clr,
        input  we, waddr, armed, triggered, capture_done, trig_addr, state
    );

endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: fill, arm, trigger and post-trigger phases over a circular sample RAM.
// The buffer freezes in DONE until cmd_cfg releases it with cap_done_clr.
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int AW = LA_AW
) (
    input  logic         clk,
    input  logic         rst_n,
    capture_ctrl_if.slave cap
);

    localparam int           DEPTH   = 2 ** AW;
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(DEPTH);

    cap_state_t    state_q, state_n;
    logic [AW-1:0] waddr_q, waddr_n;
    logic [AW-1:0] trig_addr_q, trig_addr_n;
    logic [AW:0]   smpl_cnt_q, smpl_cnt_n;
    logic [AW-1:0] post_cnt_q, post_cnt_n;
    logic          armed_q, armed_n;
    logic          trig_q, trig_n;
    logic          done_q, done_n;
    logic          we;

    assign we = cap.wrt_smpl & (state_q inside {FILL, ARMED, POST});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            armed_q     <= 1'b0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            waddr_q     <= waddr_n;
            trig_addr_q <= trig_addr_n;
            smpl_cnt_q  <= smpl_cnt_n;
            post_cnt_q  <= post_cnt_n;
            armed_q     <= armed_n;
            trig_q      <= trig_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        waddr_n     = waddr_q;
        trig_addr_n = trig_addr_q;
        smpl_cnt_n  = smpl_cnt_q;
        post_cnt_n  = post_cnt_q;
        armed_n     = armed_q;
        trig_n      = trig_q;
        done_n      = done_q;

        if (we) waddr_n = waddr_q + 1'b1;

        // trig_addr takes the post-write address so it points at the oldest sample.
        unique case (state_q)
            IDLE: begin
                if (cap.run) begin
                    state_n    = FILL;
                    smpl_cnt_n = '0;
                    post_cnt_n = '0;
                    armed_n    = 1'b0;
                    trig_n     = 1'b0;
                end
            end
            FILL: begin
                if (!cap.run) begin
                    state_n = IDLE;
                    armed_n = 1'b0;
                    trig_n  = 1'b0;
                end else if (we) begin
                    smpl_cnt_n = (smpl_cnt_q == DEPTH_C) ? smpl_cnt_q : smpl_cnt_q + 1'b1;
                    if (smpl_cnt_n == DEPTH_C - {1'b0, cap.trig_pos}) begin
                        state_n = ARMED;
                        armed_n = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (!cap.run) begin
                    state_n = IDLE;
                    armed_n = 1'b0;
                    trig_n  = 1'b0;
                end else if (cap.trig) begin
                    trig_n = 1'b1;
                    if (cap.trig_pos == '0) begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        armed_n     = 1'b0;
                        trig_addr_n = waddr_n;
                    end else begin
                        state_n = POST;
                    end
                end
            end
            POST: begin
                if (!cap.run) begin
                    state_n = IDLE;
                    armed_n = 1'b0;
                    trig_n  = 1'b0;
                end else if (we) begin
                    post_cnt_n = post_cnt_q + 1'b1;
                    if (post_cnt_n == cap.trig_pos) begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        armed_n     = 1'b0;
                        trig_addr_n = waddr_n;
                    end
                end
            end
            DONE: begin
                if (cap.cap_done_clr) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cap.we           = we;
    assign cap.waddr        = waddr_q;
    assign cap.armed        = armed_q;
    assign cap.triggered    = trig_q;
    assign cap.capture_done = done_q;
    assign cap.trig_addr    = trig_addr_q;
    assign cap.state        = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed capture scenarios, then random traffic against a
// flag-and-counter model of the capture rules.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  capture_ctrl_if #(.AW(AW)) cif ();

  capture_ctrl #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cap   (cif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: m_cap = capture running; fill/armed/post phase is read off the flags.
  bit m_cap, m_armed, m_trig, m_done;
  int m_addr, m_taddr, m_fill, m_post;
  bit prev_done;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_armed = 0; m_trig = 0; m_done = 0;
    m_addr = 0; m_taddr = 0; m_fill = 0; m_post = 0;
    prev_done = 0;
    exp_q.delete();
  endtask

  task automatic model_finish();
    m_cap   = 0;
    m_done  = 1;
    m_armed = 0;
    m_taddr = m_addr;
    exp_q.push_back(AW'(m_taddr));
  endtask

  task automatic model_edge();
    bit wr;
    int tp;
    wr = cif.wrt_smpl;
    tp = int'(cif.trig_pos);
    if (m_done) begin
      if (cif.cap_done_clr) m_done = 0;
    end else if (!m_cap) begin
      if (cif.run) begin
        m_cap = 1; m_fill = 0; m_post = 0; m_armed = 0; m_trig = 0;
      end
    end else begin
      if (wr) m_addr = (m_addr + 1) % DEPTH;
      if (!cif.run) begin
        m_cap = 0; m_armed = 0; m_trig = 0;
      end else if (!m_armed) begin
        if (wr) begin
          m_fill++;
          if (m_fill == DEPTH - tp) m_armed = 1;
        end
      end else if (!m_trig) begin
        if (cif.trig) begin
          m_trig = 1;
          if (tp == 0) model_finish();
        end
      end else if (wr) begin
        m_post++;
        if (m_post == tp) model_finish();
      end
    end
  endtask

  task automatic check_outputs();
    chk("we",           32'(cif.we),           32'(cif.wrt_smpl & m_cap));
    chk("waddr",        32'(cif.waddr),        32'(m_addr));
    chk("armed",        32'(cif.armed),        32'(m_armed));
    chk("triggered",    32'(cif.triggered),    32'(m_trig));
    chk("capture_done", 32'(cif.capture_done), 32'(m_done));
    chk("trig_addr",    32'(cif.trig_addr),    32'(m_taddr));
    if (cif.capture_done === 1'b1 && !prev_done) begin
      chk("done_pending", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) chk("done_trig_addr", 32'(cif.trig_addr), 32'(exp_q.pop_front()));
    end
    prev_done = (cif.capture_done === 1'b1);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},        32'(cif.we),           32'd0);
    chk({tag, "_waddr"},     32'(cif.waddr),        32'd0);
    chk({tag, "_armed"},     32'(cif.armed),        32'd0);
    chk({tag, "_triggered"}, 32'(cif.triggered),    32'd0);
    chk({tag, "_done"},      32'(cif.capture_done), 32'd0);
    chk({tag, "_trig_addr"}, 32'(cif.trig_addr),    32'd0);
    chk({tag, "_state"},     32'(cif.state),        32'(IDLE));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    cif.run = 1'b0; cif.wrt_smpl = 1'b0; cif.trig = 1'b0;
    cif.trig_pos = '0; cif.cap_done_clr = 1'b0;
    #2;
    cif.wrt_smpl = 1'b1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // trig_pos=6, continuous writes, trigger on write 13
    cif.trig_pos = 4'd6; cif.run = 1'b1; cif.wrt_smpl = 1'b1;
    step();
    repeat (9) step();
    chk("s1_armed_after9", 32'(cif.armed), 32'd0);
    step();
    chk("s1_armed_after10", 32'(cif.armed), 32'd1);
    repeat (2) step();
    cif.trig = 1'b1;
    step();
    cif.trig = 1'b0;
    chk("s1_triggered", 32'(cif.triggered), 32'd1);
    repeat (5) step();
    chk("s1_done_early", 32'(cif.capture_done), 32'd0);
    step();
    chk("s1_done", 32'(cif.capture_done), 32'd1);
    chk("s1_waddr", 32'(cif.waddr), 32'd3);
    chk("s1_trig_addr", 32'(cif.trig_addr), 32'd3);

    // frozen buffer ignores run drop and write strobes
    cif.run = 1'b0;
    repeat (3) step();
    chk("s5_we_frozen", 32'(cif.we), 32'd0);
    chk("s5_waddr_frozen", 32'(cif.waddr), 32'd3);
    chk("s5_done_held", 32'(cif.capture_done), 32'd1);
    cif.cap_done_clr = 1'b1;
    step();
    cif.cap_done_clr = 1'b0;
    chk("s5_done_cleared", 32'(cif.capture_done), 32'd0);
    chk("s5_idle", 32'(cif.state), 32'(IDLE));

    // trig_pos=0: full buffer, trigger freezes immediately
    cif.trig_pos = 4'd0; cif.run = 1'b1;
    step();
    repeat (15) step();
    chk("s2_armed_after15", 32'(cif.armed), 32'd0);
    step();
    chk("s2_armed_after16", 32'(cif.armed), 32'd1);
    cif.wrt_smpl = 1'b0; cif.trig = 1'b1;
    step();
    cif.trig = 1'b0;
    chk("s2_done", 32'(cif.capture_done), 32'd1);
    chk("s2_waddr", 32'(cif.waddr), 32'd3);
    chk("s2_trig_addr", 32'(cif.trig_addr), 32'd3);
    cif.wrt_smpl = 1'b1;
    step();
    chk("s2_no_extra_write", 32'(cif.waddr), 32'd3);
    cif.cap_done_clr = 1'b1;
    step();
    cif.cap_done_clr = 1'b0;
    chk("s2_clr_idle", 32'(cif.state), 32'(IDLE));
    step();
    chk("s2_refill", 32'(cif.state), 32'(FILL));
    cif.run = 1'b0;
    step();

    // trig held high from run rise, trig_pos=4
    cif.trig_pos = 4'd4; cif.trig = 1'b1; cif.run = 1'b1;
    step();
    repeat (11) step();
    chk("s3_armed_after11", 32'(cif.armed), 32'd0);
    chk("s3_trig_in_fill", 32'(cif.triggered), 32'd0);
    step();
    chk("s3_armed_after12", 32'(cif.armed), 32'd1);
    chk("s3_trig_not_yet", 32'(cif.triggered), 32'd0);
    step();
    chk("s3_trig_first_armed", 32'(cif.triggered), 32'd1);
    repeat (4) step();
    chk("s3_done", 32'(cif.capture_done), 32'd1);
    cif.trig = 1'b0; cif.run = 1'b0; cif.cap_done_clr = 1'b1;
    step();
    cif.cap_done_clr = 1'b0;

    // abort in POST, clr in ARMED ignored, then fresh fill
    cif.trig_pos = 4'd5; cif.run = 1'b1;
    step();
    repeat (11) step();
    chk("s4_armed", 32'(cif.armed), 32'd1);
    cif.cap_done_clr = 1'b1;
    step();
    cif.cap_done_clr = 1'b0;
    chk("s4_clr_armed_state", 32'(cif.state), 32'(ARMED));
    chk("s4_clr_armed_done", 32'(cif.capture_done), 32'd0);
    cif.trig = 1'b1;
    step();
    cif.trig = 1'b0;
    repeat (2) step();
    cif.run = 1'b0;
    step();
    chk("s4_abort_state", 32'(cif.state), 32'(IDLE));
    chk("s4_abort_armed", 32'(cif.armed), 32'd0);
    chk("s4_abort_trig", 32'(cif.triggered), 32'd0);
    chk("s4_abort_done", 32'(cif.capture_done), 32'd0);
    cif.run = 1'b1;
    step();
    repeat (10) step();
    chk("s4_refill_10", 32'(cif.armed), 32'd0);
    step();
    chk("s4_refill_11", 32'(cif.armed), 32'd1);

    // async reset mid-FILL and mid-DONE
    cif.run = 1'b0;
    step();
    cif.trig_pos = 4'd3; cif.run = 1'b1;
    repeat (5) step();
    do_reset("s6_fill");
    repeat (14) step();
    chk("s6_armed", 32'(cif.armed), 32'd1);
    cif.trig = 1'b1;
    step();
    cif.trig = 1'b0;
    repeat (3) step();
    chk("s6_done", 32'(cif.capture_done), 32'd1);
    do_reset("s6_done");
    repeat (2) step();
    chk("s6_restart_waddr", 32'(cif.waddr), 32'd1);

    // random traffic; trig_pos only moves while run is low
    cif.run = 1'b0;
    step();
    for (int i = 0; i < 800; i++) begin
      cif.wrt_smpl     = ($urandom_range(0, 3) != 0);
      cif.trig         = ($urandom_range(0, 7) == 0);
      cif.cap_done_clr = ($urandom_range(0, 5) == 0);
      if (!cif.run) begin
        cif.trig_pos = AW'($urandom_range(0, DEPTH - 1));
        cif.run      = ($urandom_range(0, 3) == 0);
      end else begin
        cif.run = ($urandom_range(0, 63) != 0);
      end
      step();
    end

    cif.run = 1'b0; cif.cap_done_clr = 1'b1; cif.trig = 1'b0;
    repeat (3) step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
